// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the writeback-stage state encoding.
package riscv_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF      = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// Retiring-instruction handshake from MEM into the writeback stage.
interface wb_stage_if import riscv_pkg::*; #(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] rd_in;
  logic                  reg_we_in;
  logic                  mem_to_reg;
  logic [2:0]            funct3;
  logic [XLEN-1:0]       alu_result;

  modport master (
    output in_valid, rd_in, reg_we_in, mem_to_reg, funct3, alu_result,
    input  in_ready
  );

  modport slave (
    input  in_valid, rd_in, reg_we_in, mem_to_reg, funct3, alu_result,
    output in_ready
  );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/halfword lane out of a load word and extends it.
module load_align import riscv_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            err
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Halfword lane ignores addr_lo[0] so misaligned halves read the aligned lane.
  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LBU: data = {{(XLEN-8){1'b0}}, lane_b};
      F3_LH: begin
        data = {{(XLEN-16){lane_h[15]}}, lane_h};
        err  = addr_lo[0];
      end
      F3_LHU: begin
        data = {{(XLEN-16){1'b0}}, lane_h};
        err  = addr_lo[0];
      end
      F3_LW: begin
        data = rdata;
        err  = |addr_lo;
      end
      default: begin
        data = rdata;
        err  = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and loads as single register-file writes,
// holding off upstream while a load response is outstanding.
module wb_stage import riscv_pkg::*; #(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_stage_if.slave             bus,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic [REG_ADDR_W-1:0] Rd,
  output logic [XLEN-1:0]       reg_write_data,
  output logic                  reg_write,
  output logic                  pend_valid,
  output logic [REG_ADDR_W-1:0] pend_rd,
  output logic                  align_err,
  output logic [CNT_W-1:0]      retired
);
  wb_state_t             state, state_nxt;
  logic                  accept;
  logic                  rsp_take;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            lo_q;
  logic [XLEN-1:0]       data_q;
  logic [XLEN-1:0]       ld_data;
  logic                  ld_err;

  assign accept   = bus.in_valid & bus.in_ready;
  assign rsp_take = (state == WB_WAIT_MEM) & mem_rsp_valid;

  load_align #(.XLEN(XLEN)) u_align (
    .rdata   (mem_rdata),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .data    (ld_data),
    .err     (ld_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WB_IDLE, WB_WRITE: begin
        if (accept)                 state_nxt = bus.mem_to_reg ? WB_WAIT_MEM : WB_WRITE;
        else if (state == WB_WRITE) state_nxt = WB_IDLE;
      end
      WB_WAIT_MEM: if (mem_rsp_valid) state_nxt = WB_WRITE;
      default:     state_nxt = WB_IDLE;
    endcase
  end

  // x0 is architecturally zero, so its write is suppressed but it still retires.
  always_comb begin
    bus.in_ready = 1'b1;
    pend_valid   = 1'b0;
    pend_rd      = '0;
    reg_write    = 1'b0;
    case (state)
      WB_WAIT_MEM: begin
        bus.in_ready = 1'b0;
        pend_valid   = 1'b1;
        pend_rd      = rd_q;
      end
      WB_WRITE: reg_write = we_q & (rd_q != '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      lo_q      <= '0;
      data_q    <= '0;
      align_err <= 1'b0;
      retired   <= '0;
    end else begin
      if (accept) begin
        rd_q <= bus.rd_in;
        we_q <= bus.reg_we_in;
        if (bus.mem_to_reg) begin
          f3_q <= bus.funct3;
          lo_q <= bus.alu_result[1:0];
        end else begin
          data_q <= bus.alu_result;
        end
      end
      if (rsp_take) begin
        data_q    <= ld_data;
        align_err <= align_err | ld_err;
      end
      // Counted on entry to WRITE so the count is visible alongside the write.
      if ((accept & ~bus.mem_to_reg) | rsp_take) retired <= retired + CNT_W'(1);
    end
  end

  assign Rd             = rd_q;
  assign reg_write_data = data_q;
endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage with a lane-arithmetic load model.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic [4:0]  Rd;
  logic [31:0] reg_write_data;
  logic        reg_write;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        align_err;
  logic [31:0] retired;

  wb_stage_if bus ();

  wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rdata      (mem_rdata),
    .Rd             (Rd),
    .reg_write_data (reg_write_data),
    .reg_write      (reg_write),
    .pend_valid     (pend_valid),
    .pend_rd        (pend_rd),
    .align_err      (align_err),
    .retired        (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    longint      cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  bit          exp_err = 1'b0;
  logic [31:0] last_ret = '0;
  int          mon_ret = 0;
  exp_t        e;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @cyc %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lo);
    int unsigned b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_err(input logic [2:0] f3, input logic [1:0] lo);
    if (f3 == 3'd1 || f3 == 3'd5) return lo[0];
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd2)               return lo != 2'd0;
    return 1'b1;
  endfunction

  // Every retirement pops one expected write; register writes without retirement are errors.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_ret = '0;
      mon_ret  = 0;
    end else if (retired !== last_ret) begin
      last_ret = retired;
      mon_ret++;
      chk("sb_has_entry", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_rd", 64'(Rd), 64'(e.rd));
        chk("wb_data", 64'(reg_write_data), 64'(e.data));
        chk("wb_we", 64'(reg_write), 64'(e.we));
        chk("wb_retired", 64'(retired), 64'(mon_ret));
        chk("wb_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      chk("spurious_write", 64'(reg_write), 0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("ready_timeout", 64'(bus.in_ready), 1);
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic we, input logic [31:0] val);
    bus.in_valid   = 1'b1;
    bus.rd_in      = rd;
    bus.reg_we_in  = we;
    bus.mem_to_reg = 1'b0;
    bus.funct3     = 3'($urandom);
    bus.alu_result = val;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_alu(input logic [4:0] rd, input logic we, input logic [31:0] val);
    exp_t x;
    set_alu(rd, we, val);
    mem_rsp_valid = 1'($urandom);
    mem_rdata     = $urandom;
    wait_ready();
    x.rd = rd; x.data = val; x.we = we && (rd != 0); x.cyc = cyc + 1;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic send_load(input logic [4:0] rd, input logic we, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] word, input int dly,
                           input bit hold, input logic [4:0] h_rd, input logic [31:0] h_val);
    exp_t        x;
    logic [31:0] addr;
    addr           = $urandom;
    addr[1:0]      = lo;
    bus.in_valid   = 1'b1;
    bus.rd_in      = rd;
    bus.reg_we_in  = we;
    bus.mem_to_reg = 1'b1;
    bus.funct3     = f3;
    bus.alu_result = addr;
    mem_rsp_valid  = 1'($urandom);
    mem_rdata      = $urandom;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    if (hold) set_alu(h_rd, 1'b1, h_val);
    else      bus.in_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    for (int i = 1; i <= dly; i++) begin
      chk("stall_in_ready", 64'(bus.in_ready), 0);
      chk("stall_pend_valid", 64'(pend_valid), 1);
      chk("stall_pend_rd", 64'(pend_rd), 64'(rd));
      if (i < dly) @(negedge clk);
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = word;
    x.rd = rd; x.data = ref_load(word, f3, lo); x.we = we && (rd != 0); x.cyc = cyc + 1;
    sb.push_back(x);
    exp_err = exp_err | ref_err(f3, lo);
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("write_pend_valid", 64'(pend_valid), 0);
    if (hold) begin
      x.rd = h_rd; x.data = h_val; x.we = (h_rd != 0); x.cyc = cyc + 1;
      sb.push_back(x);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    chk("align_err", 64'(align_err), 64'(exp_err));
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rsp_valid = 1'($urandom);
      mem_rdata     = $urandom;
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.rd_in      = '0;
    bus.reg_we_in  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.funct3     = '0;
    bus.alu_result = '0;
    mem_rsp_valid  = 1'b0;
    mem_rdata      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", 64'(Rd), 0);
    chk("rst_data", 64'(reg_write_data), 0);
    chk("rst_we", 64'(reg_write), 0);
    chk("rst_pend_valid", 64'(pend_valid), 0);
    chk("rst_pend_rd", 64'(pend_rd), 0);
    chk("rst_align_err", 64'(align_err), 0);
    chk("rst_retired", 64'(retired), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Load dropped by a reset pulse while waiting for memory.
    bus.in_valid = 1'b1; bus.rd_in = 5'd9; bus.reg_we_in = 1'b1;
    bus.mem_to_reg = 1'b1; bus.funct3 = 3'd2; bus.alu_result = 32'h100;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midld_pend_valid", 64'(pend_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("midld_retired", 64'(retired), 0);
    chk("midld_pend_valid", 64'(pend_valid), 0);
    chk("midld_in_ready", 64'(bus.in_ready), 1);

    send_alu(5'd2, 1'b1, 32'hF0);
    send_alu(5'd0, 1'b1, 32'd5);
    send_alu(5'd7, 1'b0, 32'h1234);
    send_load(5'd3, 1'b1, 3'd0, 2'd0, 32'h8070_F0A5, 1, 0, 0, 0);
    send_load(5'd5, 1'b1, 3'd4, 2'd1, 32'h8070_F0A5, 2, 0, 0, 0);
    send_load(5'd6, 1'b1, 3'd1, 2'd2, 32'h8070_F0A5, 1, 0, 0, 0);
    send_load(5'd8, 1'b1, 3'd1, 2'd1, 32'h8070_F0A5, 1, 0, 0, 0);
    send_load(5'd4, 1'b1, 3'd2, 2'd0, 32'hCAFE_0001, 3, 1, 5'd10, 32'h55AA);
    // Back-to-back ALU ops: one write per cycle.
    for (int i = 0; i < 4; i++) begin
      exp_t x;
      set_alu(5'(11 + i), 1'b1, 32'(i * 3 + 1));
      x.rd = 5'(11 + i); x.data = 32'(i * 3 + 1); x.we = 1'b1; x.cyc = cyc + 1;
      sb.push_back(x);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;

    for (int n = 0; n < 80; n++) begin
      int r;
      r = int'($urandom_range(9, 0));
      if (r < 5)
        send_alu(5'($urandom), 1'($urandom), $urandom);
      else if (r < 9)
        send_load(5'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom,
                  int'($urandom_range(4, 1)), ($urandom_range(2, 0) == 0),
                  5'($urandom), $urandom);
      else
        idle(int'($urandom_range(3, 1)));
    end

    idle(4);
    chk("sb_drained", 64'(sb.size()), 0);
    chk("final_align_err", 64'(align_err), 64'(exp_err));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
